ip_hdr_checksum_tap: RTL and testbench
======================================

Name: ip_hdr_checksum_tap

Overview:
- Registered pass-through tap on the 256-bit AXI-Stream path of the router output port lookup pipeline.
- Buffers the stream in a parametrised fall-through FIFO.
- Watches handshaked output beats and verifies the full IPv4 header checksum using one's-complement folding.
- Also extracts the 32-bit destination IP and keeps saturating per-class packet counters, with a clear input for software.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master data width; only 256 is supported.
- C_S_AXIS_DATA_WIDTH, 256, slave data width; must equal the master width.
- C_M_AXIS_TUSER_WIDTH, 128, master TUSER width.
- C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width.
- FIFO_DEPTH_BITS, 2, FIFO depth is 2**FIFO_DEPTH_BITS entries (1..6).
- NUM_PORTS, 4, number of MAC/CPU port pairs encoded in the TUSER source-port field (1..8).
- SRC_PORT_POS, 16, LSB of the one-hot source-port field in TUSER.
- C_COUNTER_WIDTH, 32, width of every counter.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_RESETN  in  1  reset, asynchronous, active-low.
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  input stream.
- S_AXIS_TREADY  out  1  input stream ready.
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  output stream.
- M_AXIS_TREADY  in  1  output stream ready.
- counters_clear  in  1  single-cycle synchronous clear of all counters.
- cpu_count  out  C_COUNTER_WIDTH  packets whose source is a CPU port.
- ipv4_count  out  C_COUNTER_WIDTH  packets with ethertype 0x0800.
- bad_csum_count  out  C_COUNTER_WIDTH  IPv4 packets that fail the checksum.
- runt_count  out  C_COUNTER_WIDTH  single-beat packets.
- dst_ip  out  32  destination IP of the last checked IPv4 packet.
- csum_ok  out  1  result of the last checksum check.
- hdr_valid  out  1  one-cycle pulse when dst_ip and csum_ok update.

Behaviour:
- Reset: FIFO emptied; FSM in HDR0; all counters 0; dst_ip 0; csum_ok 0; hdr_valid 0. All are asynchronous reset values.
- Stream handshake:
  - M_AXIS_TVALID = !empty.
  - S_AXIS_TREADY = !nearly_full, where nearly_full means at most one free entry.
  - Write on S_AXIS_TVALID & S_AXIS_TREADY; read on M_AXIS_TVALID & M_AXIS_TREADY (a "beat").
  - Data, TSTRB, TUSER and TLAST pass through unmodified.
  - Minimum latency 1 cycle; full throughput when TREADY stays high.
  - Simultaneous read and write while full is legal; occupancy is unchanged.
- FSM states: HDR0, HDR1, BODY. FSM advances only on a beat.
- HDR0 beat:
  - Capture ethertype = TDATA[159:144].
  - Partial sum = the nine 16-bit words TDATA[143:128] down to TDATA[15:0], held in a 20-bit register.
  - cpu_count++ if any odd bit of TUSER[SRC_PORT_POS +: 2*NUM_PORTS] is set.
  - ipv4_count++ if ethertype == 0x0800.
  - If TLAST: runt_count++, no checksum check, stay in HDR0.
  - Otherwise go to HDR1.
- HDR1 beat:
  - If ethertype == 0x0800: sum = partial + TDATA[255:240]. Fold the carry twice: s = s[15:0] + s[19:16].
  - Next cycle: csum_ok = (folded == 16'hFFFF); dst_ip = {beat0 TDATA[15:0], TDATA[255:240]}; hdr_valid = 1 for exactly that cycle.
  - If the check fails, bad_csum_count++ in the same cycle as hdr_valid.
  - If ethertype is not 0x0800: dst_ip, csum_ok and hdr_valid are unchanged.
  - Go to HDR0 if TLAST, else BODY.
- BODY beat: go to HDR0 on TLAST; no other action.
- Counters:
  - Saturate at all-ones; no wrap.
  - counters_clear in the same cycle as an increment: the counter becomes 1.
  - counters_clear does not affect the FSM, FIFO, dst_ip or csum_ok.
- The IHL field is ignored; only 20-byte headers are checked.
- Reset mid-packet: residual upstream beats after reset release are treated as a new packet starting in HDR0.
- TVALID deasserting between beats does not change state.

Test Plan:
- IPv4 header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, 3-beat packet, TREADY=1 -> hdr_valid pulse 1 cycle after beat 1; dst_ip=0xC0A800C7; csum_ok=1; ipv4_count=1; bad_csum_count=0.
- Same packet with checksum field 0xB862 -> csum_ok=0, bad_csum_count=1; stream data at the output is bit-identical to the input.
- ARP packet (ethertype 0x0806, 2 beats) after the packet above -> no hdr_valid; dst_ip stays 0xC0A800C7; ipv4_count unchanged.
- Single-beat packet with TUSER[SRC_PORT_POS+1]=1 -> runt_count=1, cpu_count=1, no hdr_valid; the next packet is parsed from HDR0.
- M_AXIS_TREADY held low for 10 cycles while the source streams -> S_AXIS_TREADY drops once occupancy reaches 2**FIFO_DEPTH_BITS-1; no beat lost or duplicated after release.
- counters_clear asserted on the same cycle as a CPU-port HDR0 beat -> cpu_count=1. Preload a counter to all-ones and add another event -> it holds at all-ones.

Source files
------------

// File: rtl/ip_hdr_checksum_tap.sv
// ip_hdr_checksum_tap: registered AXI-Stream tap with a fall-through FIFO,
// IPv4 header checksum check, dst IP capture and saturating counters.

module ip_hdr_checksum_tap #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 2,
  parameter int NUM_PORTS            = 4,
  parameter int SRC_PORT_POS         = 16,
  parameter int C_COUNTER_WIDTH      = 32
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,

  input  logic                              counters_clear,
  output logic [C_COUNTER_WIDTH-1:0]        cpu_count,
  output logic [C_COUNTER_WIDTH-1:0]        ipv4_count,
  output logic [C_COUNTER_WIDTH-1:0]        bad_csum_count,
  output logic [C_COUNTER_WIDTH-1:0]        runt_count,
  output logic [31:0]                       dst_ip,
  output logic                              csum_ok,
  output logic                              hdr_valid
);

  localparam int DW    = C_M_AXIS_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int UW    = C_M_AXIS_TUSER_WIDTH;
  localparam int EW    = DW + SW + UW + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int PW    = FIFO_DEPTH_BITS;
  localparam int CNTW  = FIFO_DEPTH_BITS + 1;
  localparam int CW    = C_COUNTER_WIDTH;

  localparam int C_CPU  = 0;
  localparam int C_IPV4 = 1;
  localparam int C_BAD  = 2;
  localparam int C_RUNT = 3;

  localparam logic [15:0] ET_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    HDR0 = 2'd0,
    HDR1 = 2'd1,
    BODY = 2'd2
  } state_e;

  // ---------------- FIFO ----------------

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic            wr_en, rd_en;
  logic            empty, nearly_full;
  logic [EW-1:0]   wr_entry, rd_entry;

  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_strb;
  logic [UW-1:0]   m_user;
  logic            m_last;
  logic            beat;

  assign empty       = (count_q == '0);
  assign nearly_full = (count_q >= CNTW'(DEPTH - 1));

  assign S_AXIS_TREADY = !nearly_full;
  assign M_AXIS_TVALID = !empty;

  assign wr_en = S_AXIS_TVALID & !nearly_full;
  assign rd_en = !empty & M_AXIS_TREADY;
  assign beat  = rd_en;

  assign wr_entry = {S_AXIS_TLAST, S_AXIS_TUSER,
                     S_AXIS_TSTRB, S_AXIS_TDATA};
  assign rd_entry = mem_q[rd_ptr_q];

  assign {m_last, m_user, m_strb, m_data} = rd_entry;

  assign M_AXIS_TDATA = m_data;
  assign M_AXIS_TSTRB = m_strb;
  assign M_AXIS_TUSER = m_user;
  assign M_AXIS_TLAST = m_last;

  // Storage array: data only, no reset needed.
  always_ff @(posedge AXI_ACLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case (1'b1)
      (wr_en & !rd_en): count_d = count_q + CNTW'(1);
      (rd_en & !wr_en): count_d = count_q - CNTW'(1);
      default:          count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------- Parser FSM ----------------

  state_e state_q, state_d;
  logic   hdr0_beat, hdr1_beat;

  // State register.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) state_q <= HDR0;
    else             state_q <= state_d;
  end

  // Next state: advance only on an output beat.
  always_comb begin
    state_d = state_q;
    if (beat) begin
      unique case (state_q)
        HDR0:    state_d = m_last ? HDR0 : HDR1;
        HDR1:    state_d = m_last ? HDR0 : BODY;
        BODY:    state_d = m_last ? HDR0 : BODY;
        default: state_d = HDR0;
      endcase
    end
  end

  // Output decode: which header beat is leaving now.
  always_comb begin
    hdr0_beat = 1'b0;
    hdr1_beat = 1'b0;
    if (beat) begin
      unique case (state_q)
        HDR0:    hdr0_beat = 1'b1;
        HDR1:    hdr1_beat = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- Header datapath ----------------

  logic [15:0] ethertype_q;
  logic [19:0] psum_q;
  logic [15:0] ip_hi_q;

  logic [19:0] psum_nine;
  logic [19:0] sum10;
  logic [19:0] fold1;
  logic [15:0] folded;
  logic        csum_good;
  logic        check_fire;
  logic        cpu_hit;
  logic        is_ipv4_now;

  // Beat-0 partial sum of the first nine header words.
  always_comb begin
    psum_nine = '0;
    for (int i = 0; i < 9; i++) begin
      psum_nine = psum_nine + 20'(m_data[16*i +: 16]);
    end
  end

  // Add the last header word and fold the carries back in twice.
  always_comb begin
    sum10     = psum_q + 20'(m_data[255:240]);
    fold1     = 20'(sum10[15:0]) + 20'(sum10[19:16]);
    folded    = fold1[15:0] + 16'(fold1[19:16]);
    csum_good = (folded == 16'hFFFF);
  end

  // Any CPU port (odd bit of each MAC/CPU pair) marks a CPU packet.
  always_comb begin
    cpu_hit = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cpu_hit = cpu_hit | m_user[SRC_PORT_POS + 2*p + 1];
    end
  end

  assign is_ipv4_now = (m_data[159:144] == ET_IPV4);
  assign check_fire  = hdr1_beat & (ethertype_q == ET_IPV4);

  // Capture beat-0 header context for the beat-1 check.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      ethertype_q <= '0;
      psum_q      <= '0;
      ip_hi_q     <= '0;
    end else if (hdr0_beat) begin
      ethertype_q <= m_data[159:144];
      psum_q      <= psum_nine;
      ip_hi_q     <= m_data[15:0];
    end
  end

  logic [31:0] dst_ip_q;
  logic        csum_ok_q;
  logic        hdr_valid_q;

  // Publish the check result and dst IP one cycle after beat 1.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      dst_ip_q    <= '0;
      csum_ok_q   <= 1'b0;
      hdr_valid_q <= 1'b0;
    end else begin
      hdr_valid_q <= check_fire;
      if (check_fire) begin
        csum_ok_q <= csum_good;
        dst_ip_q  <= {ip_hi_q, m_data[255:240]};
      end
    end
  end

  assign dst_ip    = dst_ip_q;
  assign csum_ok   = csum_ok_q;
  assign hdr_valid = hdr_valid_q;

  // ---------------- Counters ----------------

  logic [3:0]    cnt_inc;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  assign cnt_inc[C_CPU]  = hdr0_beat & cpu_hit;
  assign cnt_inc[C_IPV4] = hdr0_beat & is_ipv4_now;
  assign cnt_inc[C_RUNT] = hdr0_beat & m_last;
  assign cnt_inc[C_BAD]  = check_fire & !csum_good;

  // Saturating increment; a clear coinciding with an event leaves 1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (counters_clear)
        cnt_d[i] = cnt_inc[i] ? CW'(1) : '0;
      else if (cnt_inc[i] && !(&cnt_q[i]))
        cnt_d[i] = cnt_q[i] + CW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cpu_count      = cnt_q[C_CPU];
  assign ipv4_count     = cnt_q[C_IPV4];
  assign bad_csum_count = cnt_q[C_BAD];
  assign runt_count     = cnt_q[C_RUNT];

endmodule

// File: tb/tb_ip_hdr_checksum_tap.sv
// tb_ip_hdr_checksum_tap: directed + random packets against a
// packet-level model of the header checker and a beat scoreboard.

module tb_ip_hdr_checksum_tap;

  localparam int CW    = 4;
  localparam int SRC   = 16;
  localparam int NP    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [255:0] S_AXIS_TDATA;
  logic [31:0]  S_AXIS_TSTRB;
  logic [127:0] S_AXIS_TUSER;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TLAST;
  logic         S_AXIS_TREADY;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TREADY = 1'b1;
  logic         counters_clear;
  logic [CW-1:0] cpu_count, ipv4_count, bad_csum_count, runt_count;
  logic [31:0]  dst_ip;
  logic         csum_ok;
  logic         hdr_valid;

  ip_hdr_checksum_tap #(
    .FIFO_DEPTH_BITS(2),
    .NUM_PORTS(NP),
    .SRC_PORT_POS(SRC),
    .C_COUNTER_WIDTH(CW)
  ) dut (
    .AXI_ACLK(clk),
    .AXI_RESETN(rst_n),
    .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TSTRB(S_AXIS_TSTRB),
    .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .counters_clear(counters_clear),
    .cpu_count(cpu_count),
    .ipv4_count(ipv4_count),
    .bad_csum_count(bad_csum_count),
    .runt_count(runt_count),
    .dst_ip(dst_ip),
    .csum_ok(csum_ok),
    .hdr_valid(hdr_valid)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  typedef struct {
    logic [31:0] dst;
    logic        ok;
  } hev_t;

  int tests = 0;
  int fails = 0;
  int n_in = 0;
  int n_out = 0;

  beat_t expq[$];
  hev_t  hq[$];
  beat_t pkt[$];

  logic [CW-1:0] m_cpu = '0, m_ipv4 = '0, m_bad = '0, m_runt = '0;

  bit rmode = 1'b0;
  bit rforce = 1'b1;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  // One's-complement sum of the ten header words, carries folded fully.
  function automatic logic [15:0] ones_sum(input logic [255:0] b0,
                                           input logic [255:0] b1,
                                           input int skip);
    int unsigned s = 0;
    for (int i = 0; i < 9; i++)
      if (i != skip) s += 32'(b0[143-16*i -: 16]);
    s += 32'(b1[255:240]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  function automatic logic hdr_ok(input logic [255:0] b0,
                                  input logic [255:0] b1);
    return ones_sum(b0, b1, -1) == 16'hFFFF;
  endfunction

  // Packet-level expectation: counters and header events.
  task automatic model_pkt();
    logic [15:0] et;
    bit cpu;
    logic ok;
    et = pkt[0].d[159:144];
    cpu = 0;
    for (int p = 0; p < NP; p++)
      if (pkt[0].u[SRC + 2*p + 1]) cpu = 1;
    if (cpu) m_cpu = sat(m_cpu);
    if (et == 16'h0800) m_ipv4 = sat(m_ipv4);
    if (pkt.size() == 1) begin
      m_runt = sat(m_runt);
    end else if (et == 16'h0800) begin
      ok = hdr_ok(pkt[0].d, pkt[1].d);
      hq.push_back('{dst: {pkt[0].d[15:0], pkt[1].d[255:240]}, ok: ok});
      if (!ok) m_bad = sat(m_bad);
    end
  endtask

  task automatic model_zero();
    m_cpu = '0; m_ipv4 = '0; m_bad = '0; m_runt = '0;
  endtask

  // cmode: 0 no CPU bit, 1 only port-0 CPU bit, 2 random.
  task automatic rand_pkt(input int nb, input int kind, input int cmode);
    beat_t a[8];
    logic [15:0] et;
    for (int b = 0; b < nb; b++) begin
      a[b].d = rnd256();
      a[b].s = $urandom;
      a[b].u = {$urandom, $urandom, $urandom, $urandom};
      a[b].l = (b == nb - 1);
    end
    if (cmode == 0) a[0].u[SRC +: 2*NP] = '0;
    if (cmode == 1) a[0].u[SRC +: 2*NP] = 8'h02;
    unique case (kind)
      0, 1:    et = 16'h0800;
      2:       et = 16'h0806;
      default: et = 16'($urandom_range(0, 65535));
    endcase
    a[0].d[159:144] = et;
    if (kind == 0 && nb > 1)
      a[0].d[63:48] = ~ones_sum(a[0].d, a[1].d, 5);
    pkt.delete();
    for (int b = 0; b < nb; b++) pkt.push_back(a[b]);
  endtask

  task automatic dir_pkt(input logic [15:0] csum);
    rand_pkt(3, 3, 0);
    pkt[0].d[159:144] = 16'h0800;
    pkt[0].d[143:0] = {16'h4500, 16'h0073, 16'h0000, 16'h4000,
                       16'h4011, csum, 16'hC0A8, 16'h0001, 16'hC0A8};
    pkt[1].d[255:240] = 16'h00C7;
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_beat(input beat_t b);
    int n = 0;
    bit hs = 0;
    S_AXIS_TDATA  = b.d;
    S_AXIS_TSTRB  = b.s;
    S_AXIS_TUSER  = b.u;
    S_AXIS_TLAST  = b.l;
    S_AXIS_TVALID = 1'b1;
    while (!hs && n < 200) begin
      hs = S_AXIS_TREADY;
      @(posedge clk);
      if (!hs) begin
        @(negedge clk);
        n++;
      end
    end
    if (!hs) check("send_timeout", 0, 1);
    else begin
      expq.push_back(b);
      n_in++;
    end
    @(negedge clk);
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic send_pkt(input int gap_max);
    model_pkt();
    foreach (pkt[i]) begin
      send_beat(pkt[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) check("drain_timeout", expq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cpu_count"}, cpu_count, m_cpu);
    check({tag, "_ipv4_count"}, ipv4_count, m_ipv4);
    check({tag, "_bad_csum_count"}, bad_csum_count, m_bad);
    check({tag, "_runt_count"}, runt_count, m_runt);
  endtask

  task automatic clear_pulse();
    counters_clear = 1'b1;
    @(negedge clk);
    counters_clear = 1'b0;
    model_zero();
  endtask

  always @(negedge clk)
    M_AXIS_TREADY = rmode ? ($urandom_range(0, 3) != 0) : rforce;

  // Output scoreboard and hdr_valid timing relative to beat 1.
  int          pos = 0;
  logic [15:0] et_cur = '0;
  bit          hv_exp = 0;
  beat_t       mon_e;
  hev_t        mon_h;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pos = 0;
      hv_exp = 0;
    end else begin
      check("hdr_valid", hdr_valid, hv_exp);
      if (hdr_valid) begin
        if (hq.size() == 0) check("hdr_unexpected", 1, 0);
        else begin
          mon_h = hq.pop_front();
          check("dst_ip", dst_ip, mon_h.dst);
          check("csum_ok", csum_ok, mon_h.ok);
        end
      end
      hv_exp = 0;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (expq.size() == 0) check("beat_unexpected", 1, 0);
        else begin
          mon_e = expq.pop_front();
          check("tdata", M_AXIS_TDATA, mon_e.d);
          check("tstrb", M_AXIS_TSTRB, mon_e.s);
          check("tuser", M_AXIS_TUSER, mon_e.u);
          check("tlast", M_AXIS_TLAST, mon_e.l);
        end
        if (pos == 0) et_cur = M_AXIS_TDATA[159:144];
        if (pos == 1 && et_cur == 16'h0800) hv_exp = 1;
        pos = M_AXIS_TLAST ? 0 : pos + 1;
        n_out++;
      end
    end
  end

  beat_t keep;

  initial begin
    S_AXIS_TDATA = '0;
    S_AXIS_TSTRB = '0;
    S_AXIS_TUSER = '0;
    S_AXIS_TLAST = 1'b0;
    S_AXIS_TVALID = 1'b0;
    counters_clear = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_m_valid", M_AXIS_TVALID, 0);
    check("rst_s_ready", S_AXIS_TREADY, 1);
    check("rst_dst_ip", dst_ip, 0);
    check("rst_csum_ok", csum_ok, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check_counters("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    dir_pkt(16'hB861);
    send_pkt(0);
    drain();
    check("ip_good_dst", dst_ip, 32'hC0A800C7);
    check("ip_good_csum", csum_ok, 1);
    check("ip_good_ipv4", ipv4_count, 1);
    check("ip_good_bad", bad_csum_count, 0);
    check_counters("ip_good");

    dir_pkt(16'hB862);
    send_pkt(0);
    drain();
    check("ip_bad_csum", csum_ok, 0);
    check("ip_bad_count", bad_csum_count, 1);
    check_counters("ip_bad");

    rand_pkt(2, 2, 0);
    send_pkt(0);
    drain();
    check("arp_dst_kept", dst_ip, 32'hC0A800C7);
    check("arp_ipv4", ipv4_count, 2);
    check_counters("arp");

    rand_pkt(1, 3, 1);
    pkt[0].d[159:144] = 16'h0806;
    send_pkt(0);
    drain();
    check("runt_count", runt_count, 1);
    check("runt_cpu", cpu_count, 1);
    rand_pkt(3, 0, 0);
    send_pkt(0);
    drain();
    check("after_runt_csum", csum_ok, 1);
    check_counters("after_runt");

    rforce = 1'b0;
    repeat (2) @(negedge clk);
    rand_pkt(8, 0, 2);
    fork
      send_pkt(0);
      begin
        repeat (10) @(negedge clk);
        #3;
        check("bp_s_ready", S_AXIS_TREADY, 0);
        check("bp_occupancy", n_in - n_out, DEPTH - 1);
        check("bp_m_valid", M_AXIS_TVALID, 1);
        rforce = 1'b1;
      end
    join
    drain();
    check_counters("bp");

    rand_pkt(1, 3, 1);
    pkt[0].d[159:144] = 16'h86DD;
    model_zero();
    model_pkt();
    send_beat(pkt[0]);
    counters_clear = 1'b1;
    @(negedge clk);
    counters_clear = 1'b0;
    drain();
    check("clr_cpu", cpu_count, 1);
    check_counters("clr");

    for (int i = 0; i < 16; i++) begin
      rand_pkt(1, 2, 1);
      send_pkt(0);
    end
    drain();
    check("sat_cpu", cpu_count, {CW{1'b1}});
    check("sat_runt", runt_count, {CW{1'b1}});
    check_counters("sat");

    for (int r = 0; r < 5; r++) begin
      clear_pulse();
      rmode = 1'b1;
      for (int k = 0; k < 10; k++) begin
        rand_pkt($urandom_range(1, 4), $urandom_range(0, 3), 2);
        send_pkt(2);
      end
      drain();
      rmode = 1'b0;
      repeat (2) @(negedge clk);
      check_counters("rnd");
    end

    rforce = 1'b0;
    repeat (2) @(negedge clk);
    dir_pkt(16'hB861);
    keep = pkt[2];
    send_beat(pkt[0]);
    send_beat(pkt[1]);
    rst_n = 1'b0;
    expq.delete();
    hq.delete();
    model_zero();
    #1;
    check("mid_rst_m_valid", M_AXIS_TVALID, 0);
    check("mid_rst_dst_ip", dst_ip, 0);
    check_counters("mid_rst");
    rforce = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pkt.delete();
    pkt.push_back(keep);
    send_pkt(0);
    dir_pkt(16'hB861);
    send_pkt(0);
    drain();
    check("resid_dst", dst_ip, 32'hC0A800C7);
    check("resid_csum", csum_ok, 1);
    check_counters("resid");

    check("hdr_events_left", hq.size(), 0);
    check("beats_left", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
